subbyte_seq_ctrl: RTL and testbench

SUBBYTE_SEQ_CTRL -- requirements
Module: subbyte_seq_ctrl

---
 rtl/subbyte_seq_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_subbyte_seq_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/subbyte_seq_ctrl.sv
// ---------------------------------------------------------------------------
// subbyte_seq_ctrl
//
// Sequential byte-substitution engine. A 128-bit state and a 256-entry S-box
// table are captured on accept. The engine then substitutes BPC bytes per
// cycle until all 16 bytes are done, and holds the result until the consumer
// takes it.
//
// Parameters
//   BPC        S-box lookups per cycle (1, 2 or 4)
//
// Ports
//   clk        clock, rising edge
//   rst_n      synchronous active-low reset
//   in_data    128-bit state to substitute, byte 0 = [127:120]
//   sboxflat   2048-bit S-box table, entry i = [2047-8i -: 8]
//   in_valid   in_data / sboxflat valid this cycle
//   in_ready   block accepts a new state (IDLE only)
//   out_data   substituted state; zero whenever out_valid = 0
//   out_valid  out_data holds a completed result (DONE)
//   out_ready  consumer takes out_data this cycle
//   flush      abort and discard; overrides accept and out_ready
//   busy       substitution in progress (SUB)
// ---------------------------------------------------------------------------
module subbyte_seq_ctrl #(
  parameter int unsigned BPC = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [127:0]  in_data,
  input  logic [2047:0] sboxflat,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [127:0]  out_data,
  output logic          out_valid,
  input  logic          out_ready,
  input  logic          flush,
  output logic          busy
);

  generate
    if (!(BPC == 1 || BPC == 2 || BPC == 4)) begin : g_bpc_check
      $error("subbyte_seq_ctrl: BPC must be 1, 2 or 4");
    end
  endgenerate

  // Index of the final group of bytes processed in SUB.
  localparam logic [3:0] LAST_IDX = 4'(16 - BPC);
  localparam logic [3:0] IDX_STEP = 4'(BPC);

  typedef enum logic [1:0] {
    IDLE,
    SUB,
    DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [3:0]    idx;
  logic [127:0]  cap_data;
  logic [2047:0] cap_sbox;
  logic [7:0]    res_q [16];
  logic [127:0]  res_flat;

  logic [7:0]    sbox_tbl [256];
  logic [7:0]    din_b    [16];
  logic [3:0]    lane_pos [BPC];
  logic [7:0]    lane_val [BPC];

  logic          accept;
  logic          last_grp;

  // Byte views of the captured registers and the result.
  generate
    for (genvar g = 0; g < 256; g++) begin : g_sbox_view
      assign sbox_tbl[g] = cap_sbox[2047 - 8*g -: 8];
    end
    for (genvar g = 0; g < 16; g++) begin : g_byte_view
      assign din_b[g]                   = cap_data[127 - 8*g -: 8];
      assign res_flat[127 - 8*g -: 8]   = res_q[g];
    end
  endgenerate

  assign accept   = in_valid & in_ready;
  assign last_grp = (idx == LAST_IDX);

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next state (flush overrides every handshake)
  // -------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (accept)    state_nxt = SUB;
        SUB:     if (last_grp)  state_nxt = DONE;
        DONE:    if (out_ready) state_nxt = IDLE;
        default:                state_nxt = IDLE;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // FSM: outputs
  // -------------------------------------------------------------------------
  always_comb begin
    in_ready  = (state == IDLE);
    busy      = (state == SUB);
    out_valid = (state == DONE);
    out_data  = out_valid ? res_flat : '0;
  end

  // -------------------------------------------------------------------------
  // Lookup lanes: BPC consecutive bytes starting at idx
  // -------------------------------------------------------------------------
  always_comb begin
    for (int unsigned k = 0; k < BPC; k++) begin
      lane_pos[k] = idx + 4'(k);
      lane_val[k] = sbox_tbl[din_b[lane_pos[k]]];
    end
  end

  // -------------------------------------------------------------------------
  // Capture registers; not reset, only ever read after a fresh accept
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (accept && !flush) begin
      cap_data <= in_data;
      cap_sbox <= sboxflat;
    end
  end

  // -------------------------------------------------------------------------
  // Byte index and result register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx   <= '0;
      res_q <= '{default: '0};
    end else if (flush) begin
      idx   <= '0;
      res_q <= '{default: '0};
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            idx   <= '0;
            res_q <= '{default: '0};
          end
        end
        SUB: begin
          for (int unsigned k = 0; k < BPC; k++) begin
            res_q[lane_pos[k]] <= lane_val[k];
          end
          // Park at zero after the last group so idx never passes LAST_IDX.
          idx <= last_grp ? '0 : idx + IDX_STEP;
        end
        DONE: begin
          if (out_ready) begin
            res_q <= '{default: '0};
          end
        end
        default: begin
          idx   <= '0;
          res_q <= '{default: '0};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_subbyte_seq_ctrl.sv
module tb_subbyte_seq_ctrl;

  localparam logic [2047:0] AES_SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [127:0] VEC_A   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] EXP_A   = 128'h638293c31bfc33f5c4eeacea4bc12816;
  localparam logic [127:0] EXP_Z   = {16{8'h63}};
  localparam logic [127:0] VEC_ID  = 128'h5a4ea44fb61410af0ca81cd1a4813475;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic [127:0]  in_data;
  logic [2047:0] sboxflat;
  logic [2:0]    iv;
  logic [2:0]    ordy;
  logic [2:0]    ir;
  logic [2:0]    ov;
  logic [2:0]    bz;
  logic [127:0]  od [3];
  logic [2047:0] id_tbl;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  subbyte_seq_ctrl #(.BPC(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .sboxflat(sboxflat),
    .in_valid(iv[0]), .in_ready(ir[0]), .out_data(od[0]), .out_valid(ov[0]),
    .out_ready(ordy[0]), .flush(flush), .busy(bz[0])
  );

  subbyte_seq_ctrl #(.BPC(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .sboxflat(sboxflat),
    .in_valid(iv[1]), .in_ready(ir[1]), .out_data(od[1]), .out_valid(ov[1]),
    .out_ready(ordy[1]), .flush(flush), .busy(bz[1])
  );

  subbyte_seq_ctrl #(.BPC(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .sboxflat(sboxflat),
    .in_valid(iv[2]), .in_ready(ir[2]), .out_data(od[2]), .out_valid(ov[2]),
    .out_ready(ordy[2]), .flush(flush), .busy(bz[2])
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic accept(input int d);
    iv[d] = 1'b1;
    step();
    iv[d] = 1'b0;
  endtask

  // Waits (bounded) for out_valid; checks cycles taken and the result.
  task automatic wait_done(input int d, input int exp_lat, input logic [127:0] exp, input string tag);
    int cyc = 0;
    do begin
      step();
      cyc++;
    end while (!ov[d] && cyc < 64);
    chk({tag, "_lat"}, 128'(cyc), 128'(exp_lat));
    chk({tag, "_data"}, od[d], exp);
  endtask

  task automatic handoff(input int d, input string tag);
    ordy[d] = 1'b1;
    step();
    ordy[d] = 1'b0;
    chk({tag, "_ov_after"}, 128'(ov[d]), 128'(0));
    chk({tag, "_ir_after"}, 128'(ir[d]), 128'(1));
    chk({tag, "_od_after"}, od[d], '0);
  endtask

  initial begin
    bit seen;
    for (int i = 0; i < 256; i++) id_tbl[2047 - 8*i -: 8] = 8'(i);

    rst_n    = 1'b0;
    flush    = 1'b0;
    iv       = '0;
    ordy     = '0;
    in_data  = '0;
    sboxflat = AES_SBOX;
    step();
    step();
    for (int d = 0; d < 3; d++) begin
      chk("rst_ov", 128'(ov[d]), 128'(0));
      chk("rst_od", od[d], '0);
      chk("rst_busy", 128'(bz[d]), 128'(0));
    end
    rst_n = 1'b1;
    step();
    chk("rst_ir", 128'(ir), 128'(3'b111));

    // All-zero state, AES table, one byte per cycle, then a held DONE.
    in_data = '0;
    accept(0);
    chk("z_busy", 128'(bz[0]), 128'(1));
    chk("z_ir_sub", 128'(ir[0]), 128'(0));
    chk("z_od_sub", od[0], '0);
    wait_done(0, 16, EXP_Z, "z_b1");
    for (int i = 0; i < 10; i++) begin
      iv[0] = 1'b1;
      step();
      chk("hold_ov", 128'(ov[0]), 128'(1));
      chk("hold_od", od[0], EXP_Z);
      chk("hold_ir", 128'(ir[0]), 128'(0));
    end
    iv[0] = 1'b0;
    handoff(0, "z_b1");

    // Known-answer vector at each lanes-per-cycle setting.
    in_data = VEC_A;
    accept(0);
    wait_done(0, 16, EXP_A, "a_b1");
    handoff(0, "a_b1");
    accept(1);
    wait_done(1, 8, EXP_A, "a_b2");
    handoff(1, "a_b2");
    accept(2);
    wait_done(2, 4, EXP_A, "a_b4");
    handoff(2, "a_b4");

    // Identity table; inputs trashed 3 cycles after accept.
    sboxflat = id_tbl;
    in_data  = VEC_ID;
    accept(0);
    step();
    step();
    step();
    sboxflat = '0;
    in_data  = '1;
    wait_done(0, 13, VEC_ID, "id");
    handoff(0, "id");
    sboxflat = AES_SBOX;

    // Flush in the 5th SUB cycle with in_valid also high.
    in_data = VEC_A;
    accept(0);
    for (int i = 0; i < 4; i++) step();
    flush = 1'b1;
    iv[0] = 1'b1;
    step();
    flush = 1'b0;
    iv[0] = 1'b0;
    chk("fl_ov", 128'(ov[0]), 128'(0));
    chk("fl_ir", 128'(ir[0]), 128'(1));
    chk("fl_busy", 128'(bz[0]), 128'(0));
    chk("fl_od", od[0], '0);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (ov[0] !== 1'b0) seen = 1'b1;
    end
    chk("fl_no_ov", 128'(seen), 128'(0));
    accept(0);
    wait_done(0, 16, EXP_A, "fl_next");
    handoff(0, "fl_next");

    // One-cycle reset mid-SUB.
    in_data = '0;
    accept(0);
    for (int i = 0; i < 6; i++) step();
    rst_n = 1'b0;
    step();
    chk("mr_ov", 128'(ov[0]), 128'(0));
    chk("mr_od", od[0], '0);
    chk("mr_busy", 128'(bz[0]), 128'(0));
    rst_n = 1'b1;
    step();
    chk("mr_ir", 128'(ir[0]), 128'(1));
    chk("mr_busy2", 128'(bz[0]), 128'(0));
    in_data = VEC_A;
    accept(0);
    wait_done(0, 16, EXP_A, "mr_next");
    handoff(0, "mr_next");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
